// File: rtl/bp_fpga_dma_arb_pkg.sv
// Shared definitions for the DRAM DMA arbiter.
//   - arb_state_e          : arbiter FSM encoding
//   - bsg_cache_dma_pkt_s  : bsg_cache DMA packet layout (write_not_read in the MSB)
//   - clog2_min1()         : index/counter width helper that never returns 0
package bp_fpga_dma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } arb_state_e;

    localparam int dma_addr_width_lp = 28;

    typedef struct packed {
        logic                         write_not_read;
        logic [dma_addr_width_lp-1:0] addr;
    } bsg_cache_dma_pkt_s;

    // A single-entry index or single-beat counter still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin requester selection for the DRAM DMA arbiter.
// Ports:
//   clk_i, reset_n_i : clock, synchronous active-low reset (pointer -> 0)
//   reqs_i           : request vector
//   yumi_i           : accept the current winner; pointer moves past it
//   v_o              : at least one request present
//   grant_idx_o      : index of the winner, searched from the pointer upward
module bsg_arb_round_robin
    import bp_fpga_dma_arb_pkg::*;
#(
    parameter  int width_p      = 2,
    localparam int idx_width_lp = clog2_min1(width_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [width_p-1:0]      reqs_i,
    input  logic                    yumi_i,
    output logic                    v_o,
    output logic [idx_width_lp-1:0] grant_idx_o
);

    logic [idx_width_lp-1:0] r_ptr;
    logic                    w_found;

    function automatic logic [idx_width_lp-1:0] rot_idx(input logic [idx_width_lp-1:0] base,
                                                        input int off);
        return idx_width_lp'((int'(base) + off) % width_p);
    endfunction

    always_comb begin
        w_found     = 1'b0;
        grant_idx_o = r_ptr;
        for (int i = 0; i < width_p; i++) begin
            if (!w_found && reqs_i[rot_idx(r_ptr, i)]) begin
                w_found     = 1'b1;
                grant_idx_o = rot_idx(r_ptr, i);
            end
        end
    end

    assign v_o = w_found;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ptr <= '0;
        end else if (yumi_i && w_found) begin
            r_ptr <= (grant_idx_o == idx_width_lp'(width_p - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/dram_dma_arbiter.sv
// Shares one MIG DMA port between num_req_p bsg_cache DMA requesters.
// One transaction is in flight at a time; the packet and data paths are
// purely combinational muxes steered by the registered grantee index.
// Ports:
//   clk_i, reset_n_i                       : clock, synchronous active-low reset
//   req_pkt_i / req_pkt_v_i / req_pkt_yumi_o : per-requester DMA packets
//   req_data_o / req_data_v_o / req_data_ready_and_i : read data to requesters
//   req_data_i / req_data_v_i / req_data_yumi_o      : write data from requesters
//   dma_pkt_o / dma_pkt_v_o / dma_pkt_yumi_i          : packet to controller
//   dma_data_i / dma_data_v_i / dma_data_ready_and_o  : read data from controller
//   dma_data_o / dma_data_v_o / dma_data_yumi_i       : write data to controller
//   grant_o, busy_o                          : current owner (one-hot), not idle
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no owner; pick round-robin winner when any packet is valid
// ST_ISSUE | owner's packet presented to controller, waiting for yumi
// ST_WDATA | streaming burst_len_p write beats from owner to controller
// ST_RDATA | streaming burst_len_p read beats from controller to owner
module dram_dma_arbiter
    import bp_fpga_dma_arb_pkg::*;
#(
    parameter int num_req_p       = 2,
    parameter int dma_pkt_width_p = 29,
    parameter int data_width_p    = 64,
    parameter int burst_len_p     = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,

    input  logic [num_req_p*dma_pkt_width_p-1:0] req_pkt_i,
    input  logic [num_req_p-1:0]                 req_pkt_v_i,
    output logic [num_req_p-1:0]                 req_pkt_yumi_o,

    output logic [data_width_p-1:0]              req_data_o,
    output logic [num_req_p-1:0]                 req_data_v_o,
    input  logic [num_req_p-1:0]                 req_data_ready_and_i,

    input  logic [num_req_p*data_width_p-1:0]    req_data_i,
    input  logic [num_req_p-1:0]                 req_data_v_i,
    output logic [num_req_p-1:0]                 req_data_yumi_o,

    output logic [dma_pkt_width_p-1:0]           dma_pkt_o,
    output logic                                 dma_pkt_v_o,
    input  logic                                 dma_pkt_yumi_i,

    input  logic [data_width_p-1:0]              dma_data_i,
    input  logic                                 dma_data_v_i,
    output logic                                 dma_data_ready_and_o,

    output logic [data_width_p-1:0]              dma_data_o,
    output logic                                 dma_data_v_o,
    input  logic                                 dma_data_yumi_i,

    output logic [num_req_p-1:0]                 grant_o,
    output logic                                 busy_o
);

    localparam int idx_width_lp = clog2_min1(num_req_p);
    localparam int cnt_width_lp = clog2_min1(burst_len_p);

    arb_state_e                r_state;
    arb_state_e                w_state_next;
    logic [idx_width_lp-1:0]   r_gnt_idx;
    logic [cnt_width_lp-1:0]   r_cnt;
    logic [cnt_width_lp-1:0]   w_cnt_next;
    logic                      w_rr_v;
    logic                      w_rr_adv;
    logic [idx_width_lp-1:0]   w_rr_idx;
    logic                      w_beat;
    logic [num_req_p-1:0]      w_sel;

    logic [dma_pkt_width_p-1:0] w_pkt_arr   [num_req_p];
    logic [data_width_p-1:0]    w_wdata_arr [num_req_p];
    logic [dma_pkt_width_p-1:0] w_gnt_pkt;

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign w_pkt_arr[g]   = req_pkt_i[g*dma_pkt_width_p +: dma_pkt_width_p];
        assign w_wdata_arr[g] = req_data_i[g*data_width_p +: data_width_p];
    end

    bsg_arb_round_robin #(
        .width_p     (num_req_p)
    ) u_rr (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .reqs_i      (req_pkt_v_i),
        .yumi_i      (w_rr_adv),
        .v_o         (w_rr_v),
        .grant_idx_o (w_rr_idx)
    );

    assign w_sel      = num_req_p'(1) << r_gnt_idx;
    assign w_gnt_pkt  = w_pkt_arr[r_gnt_idx];
    assign dma_pkt_o  = w_gnt_pkt;
    assign dma_data_o = w_wdata_arr[r_gnt_idx];
    assign req_data_o = dma_data_i;

    // Status outputs are masked while reset is held so nothing stale from an
    // abandoned transaction is visible before the first reset edge.
    assign busy_o  = reset_n_i && (r_state != ST_IDLE);
    assign grant_o = busy_o ? w_sel : '0;

    always_comb begin
        w_state_next         = r_state;
        w_cnt_next           = r_cnt;
        w_rr_adv             = 1'b0;
        w_beat               = 1'b0;
        dma_pkt_v_o          = 1'b0;
        req_pkt_yumi_o       = '0;
        dma_data_v_o         = 1'b0;
        req_data_yumi_o      = '0;
        req_data_v_o         = '0;
        dma_data_ready_and_o = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rr_v) begin
                    w_rr_adv     = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dma_pkt_v_o    = req_pkt_v_i[r_gnt_idx];
                req_pkt_yumi_o = w_sel & {num_req_p{dma_pkt_yumi_i}};
                if (dma_pkt_v_o && dma_pkt_yumi_i) begin
                    w_cnt_next   = '0;
                    w_state_next = w_gnt_pkt[dma_pkt_width_p-1] ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                dma_data_v_o    = req_data_v_i[r_gnt_idx];
                req_data_yumi_o = w_sel & {num_req_p{dma_data_yumi_i}};
                w_beat          = dma_data_v_o && dma_data_yumi_i;
            end
            ST_RDATA: begin
                req_data_v_o         = w_sel & {num_req_p{dma_data_v_i}};
                dma_data_ready_and_o = req_data_ready_and_i[r_gnt_idx];
                w_beat               = dma_data_v_i && dma_data_ready_and_o;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_beat) begin
            if (r_cnt == cnt_width_lp'(burst_len_p - 1)) begin
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end

        if (!reset_n_i) begin
            w_rr_adv             = 1'b0;
            dma_pkt_v_o          = 1'b0;
            req_pkt_yumi_o       = '0;
            dma_data_v_o         = 1'b0;
            req_data_yumi_o      = '0;
            req_data_v_o         = '0;
            dma_data_ready_and_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gnt_idx <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_rr_adv) begin
                r_gnt_idx <= w_rr_idx;
            end
        end
    end

    // A granted requester must hold its packet valid until the controller
    // accepts it; dropping it would leave ISSUE waiting forever.
    a_pkt_v_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (r_state == ST_ISSUE) |-> req_pkt_v_i[r_gnt_idx]);

endmodule

// File: tb/tb_dram_dma_arbiter.sv
module tb_dram_dma_arbiter;
    import bp_fpga_dma_arb_pkg::*;

    localparam int NR = 2;
    localparam int PW = 29;
    localparam int DW = 64;
    localparam int BL = 4;

    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic [NR*PW-1:0]  req_pkt_i;
    logic [NR-1:0]     req_pkt_v_i;
    logic [NR-1:0]     req_pkt_yumi_o;
    logic [DW-1:0]     req_data_o;
    logic [NR-1:0]     req_data_v_o;
    logic [NR-1:0]     req_data_ready_and_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_data_v_i;
    logic [NR-1:0]     req_data_yumi_o;
    logic [PW-1:0]     dma_pkt_o;
    logic              dma_pkt_v_o;
    logic              dma_pkt_yumi_i;
    logic [DW-1:0]     dma_data_i;
    logic              dma_data_v_i;
    logic              dma_data_ready_and_o;
    logic [DW-1:0]     dma_data_o;
    logic              dma_data_v_o;
    logic              dma_data_yumi_i;
    logic [NR-1:0]     grant_o;
    logic              busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    dram_dma_arbiter #(
        .num_req_p       (NR),
        .dma_pkt_width_p (PW),
        .data_width_p    (DW),
        .burst_len_p     (BL)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .req_pkt_i            (req_pkt_i),
        .req_pkt_v_i          (req_pkt_v_i),
        .req_pkt_yumi_o       (req_pkt_yumi_o),
        .req_data_o           (req_data_o),
        .req_data_v_o         (req_data_v_o),
        .req_data_ready_and_i (req_data_ready_and_i),
        .req_data_i           (req_data_i),
        .req_data_v_i         (req_data_v_i),
        .req_data_yumi_o      (req_data_yumi_o),
        .dma_pkt_o            (dma_pkt_o),
        .dma_pkt_v_o          (dma_pkt_v_o),
        .dma_pkt_yumi_i       (dma_pkt_yumi_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_ready_and_o (dma_data_ready_and_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_yumi_i      (dma_data_yumi_i),
        .grant_o              (grant_o),
        .busy_o               (busy_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, failed=%0d", n_fail);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_pkt_i            = '0;
        req_pkt_v_i          = '0;
        req_data_ready_and_i = '0;
        req_data_i           = '0;
        req_data_v_i         = '0;
        dma_pkt_yumi_i       = 1'b0;
        dma_data_i           = '0;
        dma_data_v_i         = 1'b0;
        dma_data_yumi_i      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n_i = 1'b0;
        step();
        step();
        reset_n_i = 1'b1;
    endtask

    task automatic set_pkt(input int who, input logic wnr, input logic [27:0] addr);
        bsg_cache_dma_pkt_s p;
        p.write_not_read = wnr;
        p.addr           = addr;
        req_pkt_i[who*PW +: PW] = p;
    endtask

    // Entered at posedge+1 with the DUT in ISSUE for requester 'who'.
    // Handshakes the packet, then streams BL read beats base..base+BL-1,
    // counting beats that reach only 'who' with correct data and ready.
    task automatic run_read_xfer(input int who, input logic [DW-1:0] base,
                                 output logic [NR-1:0] gnt_seen, output int beats_ok);
        beats_ok       = 0;
        dma_pkt_yumi_i = 1'b1;
        @(negedge clk_i);
        gnt_seen = grant_o;
        step();
        dma_pkt_yumi_i       = 1'b0;
        req_pkt_v_i[who]     = 1'b0;
        req_data_ready_and_i = '1;
        for (int i = 0; i < BL; i++) begin
            dma_data_v_i = 1'b1;
            dma_data_i   = base + DW'(i);
            @(negedge clk_i);
            if (req_data_v_o === NR'(1 << who) && req_data_o === base + DW'(i) &&
                dma_data_ready_and_o === 1'b1 && busy_o === 1'b1)
                beats_ok++;
            step();
        end
        dma_data_v_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n_i            = 1'b0;
        req_pkt_v_i          = '1;
        dma_pkt_yumi_i       = 1'b1;
        dma_data_v_i         = 1'b1;
        req_data_ready_and_i = '1;
        req_data_v_i         = '1;
        dma_data_yumi_i      = 1'b1;
        step();
        step();
        @(negedge clk_i);
        n_tests++;
        if ({busy_o, grant_o} !== 3'b000) begin
            $display("FAIL reset_status: busy/grant=%b expected 000", {busy_o, grant_o});
            n_fail++;
        end
        n_tests++;
        if ({dma_pkt_v_o, req_pkt_yumi_o, dma_data_v_o, req_data_yumi_o,
             req_data_v_o, dma_data_ready_and_o} !== 8'b0) begin
            $display("FAIL reset_handshakes: got %b expected 00000000",
                     {dma_pkt_v_o, req_pkt_yumi_o, dma_data_v_o, req_data_yumi_o,
                      req_data_v_o, dma_data_ready_and_o});
            n_fail++;
        end
        clear_inputs();
        step();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b0 || dma_pkt_v_o !== 1'b0) begin
            $display("FAIL reset_release_idle: busy=%b pkt_v=%b expected 0 0", busy_o, dma_pkt_v_o);
            n_fail++;
        end
        step();
    endtask

    task automatic test_single_read();
        logic [NR-1:0] g;
        int            ok;
        do_reset();
        set_pkt(0, 1'b0, 28'h100);
        req_pkt_v_i = 2'b01;
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b0 || dma_pkt_v_o !== 1'b0) begin
            $display("FAIL read_pre_issue: busy=%b pkt_v=%b expected 0 0", busy_o, dma_pkt_v_o);
            n_fail++;
        end
        step();
        dma_data_v_i         = 1'b1;
        req_data_ready_and_i = '1;
        @(negedge clk_i);
        n_tests++;
        if (grant_o !== 2'b01 || dma_pkt_v_o !== 1'b1 || dma_pkt_o !== 29'h0000100) begin
            $display("FAIL read_issue: grant=%b pkt_v=%b pkt=%h expected 01 1 0000100",
                     grant_o, dma_pkt_v_o, dma_pkt_o);
            n_fail++;
        end
        n_tests++;
        if (dma_data_ready_and_o !== 1'b0 || req_data_v_o !== 2'b00 || req_pkt_yumi_o !== 2'b00) begin
            $display("FAIL read_issue_backpressure: ready=%b rdv=%b pyumi=%b expected 0 00 00",
                     dma_data_ready_and_o, req_data_v_o, req_pkt_yumi_o);
            n_fail++;
        end
        dma_data_v_i = 1'b0;
        step();
        run_read_xfer(0, 64'hA0, g, ok);
        n_tests++;
        if (g !== 2'b01 || ok !== BL) begin
            $display("FAIL read_beats: grant=%b beats=%0d expected 01 %0d", g, ok, BL);
            n_fail++;
        end
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b0 || grant_o !== 2'b00) begin
            $display("FAIL read_done: busy=%b grant=%b expected 0 00", busy_o, grant_o);
            n_fail++;
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g;
        int            ok;
        do_reset();
        set_pkt(0, 1'b0, 28'h010);
        set_pkt(1, 1'b0, 28'h020);
        req_pkt_v_i = 2'b11;
        step();
        run_read_xfer(0, 64'hC0, g, ok);
        n_tests++;
        if (g !== 2'b01 || ok !== BL) begin
            $display("FAIL rr_first: grant=%b beats=%0d expected 01 %0d", g, ok, BL);
            n_fail++;
        end
        req_pkt_v_i[0] = 1'b1;
        step();
        run_read_xfer(1, 64'hC8, g, ok);
        n_tests++;
        if (g !== 2'b10 || ok !== BL) begin
            $display("FAIL rr_second: grant=%b beats=%0d expected 10 %0d", g, ok, BL);
            n_fail++;
        end
        req_pkt_v_i[1] = 1'b1;
        step();
        run_read_xfer(0, 64'hD0, g, ok);
        n_tests++;
        if (g !== 2'b01 || ok !== BL) begin
            $display("FAIL rr_third: grant=%b beats=%0d expected 01 %0d", g, ok, BL);
            n_fail++;
        end
        req_pkt_v_i = '0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] g;
        int            ok;
        do_reset();
        set_pkt(1, 1'b0, 28'h040);
        req_pkt_v_i = 2'b10;
        step();
        run_read_xfer(1, 64'h50, g, ok);
        n_tests++;
        if (g !== 2'b10 || ok !== BL) begin
            $display("FAIL b2b_first: grant=%b beats=%0d expected 10 %0d", g, ok, BL);
            n_fail++;
        end
        req_pkt_v_i[1] = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b0 || dma_pkt_v_o !== 1'b0) begin
            $display("FAIL b2b_turnaround_idle: busy=%b pkt_v=%b expected 0 0", busy_o, dma_pkt_v_o);
            n_fail++;
        end
        step();
        @(negedge clk_i);
        n_tests++;
        if (dma_pkt_v_o !== 1'b1 || grant_o !== 2'b10) begin
            $display("FAIL b2b_regrant: pkt_v=%b grant=%b expected 1 10", dma_pkt_v_o, grant_o);
            n_fail++;
        end
        step();
        run_read_xfer(1, 64'h58, g, ok);
        n_tests++;
        if (ok !== BL) begin
            $display("FAIL b2b_second_beats: beats=%0d expected %0d", ok, BL);
            n_fail++;
        end
        step();
    endtask

    task automatic test_write();
        int k;
        int cnt0;
        int cnt1;
        do_reset();
        set_pkt(1, 1'b1, 28'h200);
        req_pkt_v_i  = 2'b10;
        req_data_v_i = 2'b11;
        step();
        dma_pkt_yumi_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (dma_pkt_o !== 29'h10000200 || req_pkt_yumi_o !== 2'b10 || dma_data_v_o !== 1'b0) begin
            $display("FAIL write_issue: pkt=%h pyumi=%b dv=%b expected 10000200 10 0",
                     dma_pkt_o, req_pkt_yumi_o, dma_data_v_o);
            n_fail++;
        end
        step();
        dma_pkt_yumi_i = 1'b0;
        req_pkt_v_i    = '0;
        k = 0; cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 16 && k < BL; c++) begin
            req_data_i      = {64'hB0 + DW'(k), 64'hDEAD};
            dma_data_yumi_i = c[0];
            @(negedge clk_i);
            n_tests++;
            if (dma_data_v_o !== 1'b1 || dma_data_o !== 64'hB0 + DW'(k) || busy_o !== 1'b1) begin
                $display("FAIL write_beat: dv=%b data=%h busy=%b expected 1 %h 1",
                         dma_data_v_o, dma_data_o, busy_o, 64'hB0 + DW'(k));
                n_fail++;
            end
            if (req_data_yumi_o[0]) cnt0++;
            if (req_data_yumi_o[1]) cnt1++;
            if (dma_data_yumi_i) k++;
            step();
        end
        dma_data_yumi_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (cnt1 !== 4 || cnt0 !== 0 || busy_o !== 1'b0 || dma_data_v_o !== 1'b0) begin
            $display("FAIL write_done: yumi1=%0d yumi0=%0d busy=%b dv=%b expected 4 0 0 0",
                     cnt1, cnt0, busy_o, dma_data_v_o);
            n_fail++;
        end
        req_data_v_i = '0;
        step();
    endtask

    task automatic test_read_stall();
        int   k;
        int   ncyc;
        logic r0;
        do_reset();
        set_pkt(0, 1'b0, 28'h300);
        req_pkt_v_i = 2'b01;
        step();
        dma_pkt_yumi_i = 1'b1;
        step();
        dma_pkt_yumi_i = 1'b0;
        req_pkt_v_i    = '0;
        k = 0; ncyc = 0;
        for (int c = 0; c < 16 && k < BL; c++) begin
            r0                   = !(c >= 2 && c < 7);
            req_data_ready_and_i = {1'b1, r0};
            dma_data_v_i         = 1'b1;
            dma_data_i           = 64'hE0 + DW'(k);
            @(negedge clk_i);
            n_tests++;
            if (dma_data_ready_and_o !== r0 || req_data_v_o !== 2'b01 ||
                req_data_o !== 64'hE0 + DW'(k)) begin
                $display("FAIL stall_cycle%0d: ready=%b rdv=%b data=%h expected %b 01 %h",
                         c, dma_data_ready_and_o, req_data_v_o, req_data_o, r0, 64'hE0 + DW'(k));
                n_fail++;
            end
            if (r0) k++;
            ncyc++;
            step();
        end
        dma_data_v_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (k !== BL || ncyc !== 9 || busy_o !== 1'b0) begin
            $display("FAIL stall_done: beats=%0d cycles=%0d busy=%b expected 4 9 0", k, ncyc, busy_o);
            n_fail++;
        end
        step();
    endtask

    task automatic test_reset_midburst();
        logic [NR-1:0] g;
        int            ok;
        do_reset();
        set_pkt(0, 1'b0, 28'h500);
        set_pkt(1, 1'b0, 28'h600);
        req_pkt_v_i = 2'b01;
        step();
        dma_pkt_yumi_i = 1'b1;
        step();
        dma_pkt_yumi_i       = 1'b0;
        req_pkt_v_i          = '0;
        req_data_ready_and_i = '1;
        dma_data_v_i         = 1'b1;
        step();
        step();
        reset_n_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if ({busy_o, grant_o, req_data_v_o, dma_data_ready_and_o} !== 6'b0) begin
            $display("FAIL midreset_during: busy/grant/rdv/ready=%b expected 000000",
                     {busy_o, grant_o, req_data_v_o, dma_data_ready_and_o});
            n_fail++;
        end
        step();
        @(negedge clk_i);
        n_tests++;
        if ({busy_o, grant_o, req_data_v_o, dma_data_ready_and_o} !== 6'b0) begin
            $display("FAIL midreset_after_edge: busy/grant/rdv/ready=%b expected 000000",
                     {busy_o, grant_o, req_data_v_o, dma_data_ready_and_o});
            n_fail++;
        end
        reset_n_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b0 || req_data_v_o !== 2'b00 || dma_data_ready_and_o !== 1'b0) begin
            $display("FAIL midreset_idle: busy=%b rdv=%b ready=%b expected 0 00 0",
                     busy_o, req_data_v_o, dma_data_ready_and_o);
            n_fail++;
        end
        step();
        dma_data_v_i = 1'b0;
        req_pkt_v_i  = 2'b11;
        step();
        run_read_xfer(0, 64'h70, g, ok);
        n_tests++;
        if (g !== 2'b01 || ok !== BL) begin
            $display("FAIL midreset_ptr0: grant=%b beats=%0d expected 01 %0d", g, ok, BL);
            n_fail++;
        end
        step();
        run_read_xfer(1, 64'h78, g, ok);
        n_tests++;
        if (g !== 2'b10 || ok !== BL) begin
            $display("FAIL midreset_req1: grant=%b beats=%0d expected 10 %0d", g, ok, BL);
            n_fail++;
        end
        step();
    endtask

    task automatic test_idle_data();
        do_reset();
        dma_data_v_i         = 1'b1;
        req_data_ready_and_i = '1;
        req_data_v_i         = '1;
        dma_data_yumi_i      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_tests++;
            if ({dma_data_ready_and_o, req_data_v_o, dma_data_v_o, req_data_yumi_o, busy_o} !== 7'b0) begin
                $display("FAIL idle_data%0d: ready/rdv/dv/dyumi/busy=%b expected 0000000", c,
                         {dma_data_ready_and_o, req_data_v_o, dma_data_v_o, req_data_yumi_o, busy_o});
                n_fail++;
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_write();
        test_read_stall();
        test_reset_midburst();
        test_idle_data();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
